mult_rr_scheduler: RTL and testbench
====================================

// Module: mult_rr_scheduler
// PURPOSE
//  Shares one 8x8 shift-add multiplier datapath between NREQ requesters.
//  Round-robin arbitration: one operand pair accepted per job over a
//  valid/ready handshake. The job runs for a fixed WIDTH cycles. The product
//  is returned with the requester ID over a valid/ready response channel.
//  Sits between requesting engines and the shared multiply resource.
// PARAMETERS
//  NREQ   4  number of requesters (2..8)
//  WIDTH  8  operand width; product is 2*WIDTH bits
//  IDW    2  requester ID width, $clog2(NREQ)
// PORTS
//  clock        in   1            system clock, rising edge
//  reset        in   1            synchronous, active-high
//  req_valid    in   NREQ         per-requester job request
//  req_a        in   NREQ*WIDTH   multiplicand, requester i at [i*WIDTH +: WIDTH]
//  req_b        in   NREQ*WIDTH   multiplier, same packing
//  req_ready    out  NREQ         one-hot accept strobe
//  rsp_valid    out  1            product available
//  rsp_ready    in   1            consumer takes product
//  rsp_id       out  IDW          requester that owns rsp_product
//  rsp_product  out  2*WIDTH      A*B, unsigned
//  busy         out  1            high in RUN or DONE
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0,
//   rsp_product=0, busy=0, acc/shift/count registers=0.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//  IDLE:
//   - grant = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NREQ.
//   - req_ready[grant]=1 combinationally in the same cycle; all other bits 0.
//   - On that edge: a_sh={WIDTH'b0,A}, b_sh=B, acc=0, cnt=WIDTH, id=grant;
//     go to RUN.
//   - No req_valid: stay in IDLE.
//  RUN, one iteration per clock:
//   - if b_sh[0]: acc += a_sh;
//   - a_sh <<= 1; b_sh >>= 1; cnt -= 1.
//   - Exactly WIDTH iterations, with no early exit on b_sh==0; latency does
//     not depend on the data.
//   - Go to DONE on the edge where cnt goes 1 -> 0.
//  DONE:
//   - rsp_valid=1; rsp_product=acc; rsp_id=id.
//   - All three outputs are held stable until rsp_ready.
//   - On rsp_valid & rsp_ready: rr_ptr=(id+1) mod NREQ; go to IDLE.
//  Latency: rsp_valid rises WIDTH clocks after the accepting edge. Earliest
//   next accept is the cycle after the response handshake, so throughput is
//   1 job per WIDTH+2 clocks.
//  req_ready is 0 throughout RUN and DONE. A requester must hold req_valid,
//   req_a and req_b stable until accepted. Dropping req_valid before accept
//   has no effect.
//  Width rules: acc is 2*WIDTH bits and never overflows
//   (255*255 = 0xFE01 at WIDTH=8). Zero operands give 0 after WIDTH cycles.
//  Reset mid-RUN or mid-DONE: the job is discarded with no response and all
//   reset values apply on the next cycle. Arbitration restarts from
//   requester 0.
//  rsp_ready high outside DONE is ignored.
// STRUCTURE
//  Package mult_pkg: state enum {IDLE, RUN, DONE}, default WIDTH/NREQ
//   localparams, rr_pick() priority-rotate function.
//  Sub-module mult_shift_add_core holds the datapath only
//   (a_sh, b_sh, acc, cnt).
//   - Inputs: load pulse, A, B.
//   - Outputs: done pulse, product.
//  The scheduler holds the FSM, the arbiter, rr_ptr, and the response
//   registers.
// TESTING
//  1. Req0 a=3 b=5 -> req_ready=0001 same cycle; after 8 clocks rsp_valid=1,
//     rsp_product=15, rsp_id=0.
//  2. Req2 a=255 b=255 -> 0xFE01, id=2. Req1 a=0 b=0xAB -> 0, still exactly
//     8 cycles of latency.
//  3. All four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0,
//     one job every 10 clocks.
//  4. rsp_ready low for 5 clocks in DONE -> rsp_valid, rsp_id and
//     rsp_product stable; req_ready=0 throughout; no new accept.
//  5. Reset pulsed on the 4th RUN cycle, with req0 and req2 pending ->
//     rsp_valid=0, busy=0 next cycle; no response for the killed job; next
//     grant goes to 0.
//  6. Req1 alone served, then req0 and req1 both valid -> rr_ptr=2, so
//     grant=0, then 1.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and helpers for the shared shift-add multiplier scheduler.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_NREQ  = 4;
    localparam int MAX_NREQ      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // First valid requester at or after ptr, wrapping modulo nreq.
    function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] valid,
                                      input logic [2:0] ptr,
                                      input int nreq);
        pick_t r;
        int    j;
        r = '0;
        // Walk the offsets downwards so the smallest matching offset is kept last.
        for (int i = MAX_NREQ - 1; i >= 0; i--) begin
            if (i < nreq) begin
                j = (int'(ptr) + i) % nreq;
                if (valid[j]) begin
                    r.found = 1'b1;
                    r.idx   = 3'(j);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_shift_add_core.sv
// Shift-add multiplier datapath: loads on a pulse, then runs exactly WIDTH
// iterations regardless of operand values.
module mult_shift_add_core
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0]   b_sh_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [CW-1:0]      cnt_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            a_sh_reg <= '0;
            b_sh_reg <= '0;
            acc_reg  <= '0;
            cnt_reg  <= '0;
        end else if (load) begin
            a_sh_reg <= {{WIDTH{1'b0}}, a};
            b_sh_reg <= b;
            acc_reg  <= '0;
            cnt_reg  <= CW'(WIDTH);
        end else if (cnt_reg != '0) begin
            if (b_sh_reg[0]) begin
                acc_reg <= acc_reg + a_sh_reg;
            end
            a_sh_reg <= a_sh_reg << 1;
            b_sh_reg <= b_sh_reg >> 1;
            cnt_reg  <= cnt_reg - CW'(1);
        end
    end

    // High during the last iteration, so the edge that retires it also ends the job.
    assign done    = (cnt_reg == CW'(1));
    assign product = acc_reg;

endmodule

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one shift-add multiplier between NREQ
// requesters, returning each product tagged with its requester ID.
module mult_rr_scheduler
    import mult_pkg::*;
#(
    parameter int NREQ  = DEFAULT_NREQ,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]    rsp_product,
    output logic                  busy
);

    state_t             state_reg;
    logic [IDW-1:0]     rr_ptr_reg;
    logic [IDW-1:0]     id_reg;
    logic               rsp_valid_reg;
    pick_t              pick;
    logic               load;
    logic               core_done;
    logic [2*WIDTH-1:0] core_product;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;

    assign pick = rr_pick(MAX_NREQ'(req_valid), 3'(rr_ptr_reg), NREQ);
    assign load = (state_reg == IDLE) && pick.found;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = load && (pick.idx == 3'(gi));
        end
    endgenerate

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                a_sel = req_a[i*WIDTH +: WIDTH];
                b_sel = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    mult_shift_add_core #(.WIDTH(WIDTH)) u_core (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .a       (a_sel),
        .b       (b_sel),
        .done    (core_done),
        .product (core_product)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            id_reg        <= '0;
            rsp_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick.found) begin
                        id_reg    <= IDW'(pick.idx);
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (core_done) begin
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        rr_ptr_reg    <= IDW'((int'(id_reg) + 1) % NREQ);
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = id_reg;
    // The accumulator is frozen once the count reaches zero, so it is stable throughout DONE.
    assign rsp_product = (state_reg == DONE) ? core_product : '0;
    assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Directed bench for mult_rr_scheduler: table-driven single jobs plus
// arbitration, back-pressure and reset-abort sequences.
module tb_mult_rr_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [2*WIDTH-1:0]    rsp_product;
    logic                  busy;

    int total_checks = 0;
    int pass_checks  = 0;

    mult_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] product;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act !== exp) begin
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end else begin
            pass_checks++;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic set_op(input int id, input logic [7:0] a, input logic [7:0] b);
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
    endtask

    // Counts rising edges until rsp_valid appears; starts just after the accepting edge.
    task automatic wait_rsp(output int lat);
        lat = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clock);
            #1 lat++;
            if (rsp_valid) return;
        end
        lat = -1;
    endtask

    task automatic run_job(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] exp_p);
        int lat;
        @(negedge clock);
        set_op(id, a, b);
        req_valid[id] = 1'b1;
        #1 check("req_ready_onehot", 32'(req_ready), 32'(1 << id));
        @(posedge clock);
        #1 req_valid[id] = 1'b0;
        wait_rsp(lat);
        check("latency", 32'(lat), 32'd8);
        check("rsp_product", 32'(rsp_product), 32'(exp_p));
        check("rsp_id", 32'(rsp_id), 32'(id));
        check("busy_done", 32'(busy), 32'd1);
        $display("job id=%0d a=%0d b=%0d -> product=0x%0h id=%0d lat=%0d",
                 id, a, b, rsp_product, rsp_id, lat);
        rsp_ready = 1'b1;
        @(posedge clock);
        #1 rsp_ready = 1'b0;
        check("rsp_valid_cleared", 32'(rsp_valid), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        int grants[5];
        int gcyc[5];
        int ng;
        logic [15:0] held_p;
        logic [1:0]  held_id;

        vecs[0] = '{0, 8'd3,   8'd5,   16'd15};
        vecs[1] = '{2, 8'd255, 8'd255, 16'hFE01};
        vecs[2] = '{1, 8'd0,   8'hAB,  16'd0};
        vecs[3] = '{3, 8'hAB,  8'd0,   16'd0};
        vecs[4] = '{3, 8'd16,  8'd16,  16'd256};

        req_a = '0;
        req_b = '0;
        reset = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check("reset_rsp_product", 32'(rsp_product), 32'd0);

        for (int v = 0; v < 5; v++) begin
            run_job(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].product);
        end

        // All requesters contending with a consumer that is always ready.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 8'(i + 1), 8'(i + 2));
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        ng = 0;
        for (int c = 0; c < 80 && ng < 5; c++) begin
            @(negedge clock);
            if (req_ready != '0) begin
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) grants[ng] = i;
                gcyc[ng] = c;
                $display("grant %0d to req %0d at cycle %0d", ng, grants[ng], c);
                ng++;
            end
        end
        check("rr_grant_count", 32'(ng), 32'd5);
        for (int k = 0; k < 5; k++) begin
            check("rr_grant_order", 32'(grants[k]), 32'(k % NREQ));
            if (k > 0) check("rr_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'd10);
        end
        req_valid = '0;

        // Back-pressure: response held for 5 clocks, a second request pending.
        do_reset();
        set_op(0, 8'd7, 8'd9);
        set_op(1, 8'd2, 8'd3);
        @(negedge clock);
        req_valid = 4'b0011;
        @(posedge clock);
        #1 req_valid[0] = 1'b0;
        wait_rsp(lat);
        check("bp_latency", 32'(lat), 32'd8);
        held_p  = rsp_product;
        held_id = rsp_id;
        check("bp_product", 32'(held_p), 32'd63);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_product", 32'(rsp_product), 32'd63);
            check("bp_rsp_id", 32'(rsp_id), 32'(held_id));
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        $display("backpressure held product=0x%0h id=%0d", rsp_product, rsp_id);
        rsp_ready = 1'b1;
        @(posedge clock);
        #1 rsp_ready = 1'b0;
        check("bp_next_grant", 32'(req_ready), 32'b0010);
        @(posedge clock);
        #1 req_valid = '0;
        wait_rsp(lat);
        check("bp_second_product", 32'(rsp_product), 32'd6);
        check("bp_second_id", 32'(rsp_id), 32'd1);
        rsp_ready = 1'b1;
        @(posedge clock);
        #1 rsp_ready = 1'b0;

        // Reset during the 4th RUN cycle kills the job.
        do_reset();
        set_op(0, 8'd11, 8'd13);
        set_op(2, 8'd5, 8'd6);
        @(negedge clock);
        req_valid = 4'b0101;
        rsp_ready = 1'b1;
        @(posedge clock);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_next_grant", 32'(req_ready), 32'b0001);
        req_valid = '0;
        lat = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clock);
            if (rsp_valid) lat++;
        end
        check("abort_no_response", 32'(lat), 32'd0);
        $display("reset abort: responses seen after reset=%0d", lat);
        rsp_ready = 1'b0;

        // Pointer advances past the last served requester.
        do_reset();
        run_job(1, 8'd4, 8'd4, 16'd16);
        set_op(0, 8'd10, 8'd10);
        set_op(1, 8'd12, 8'd12);
        @(negedge clock);
        req_valid = 4'b0011;
        #1 check("ptr_grant0", 32'(req_ready), 32'b0001);
        @(posedge clock);
        #1 req_valid[0] = 1'b0;
        wait_rsp(lat);
        check("ptr_rsp_id0", 32'(rsp_id), 32'd0);
        check("ptr_product0", 32'(rsp_product), 32'd100);
        rsp_ready = 1'b1;
        @(posedge clock);
        #1 rsp_ready = 1'b0;
        check("ptr_grant1", 32'(req_ready), 32'b0010);
        @(posedge clock);
        #1 req_valid = '0;
        wait_rsp(lat);
        check("ptr_rsp_id1", 32'(rsp_id), 32'd1);
        check("ptr_product1", 32'(rsp_product), 32'd144);
        $display("rr pointer sequence done, last id=%0d product=%0d", rsp_id, rsp_product);
        rsp_ready = 1'b1;
        @(posedge clock);
        #1 rsp_ready = 1'b0;

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
